// File: rtl/lsu_pkg.sv
// Shared types and constants for the load-store unit: FSM states, funct3 size codes,
// memory port width and an access-size helper.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_LO,
    S_LOAD_HI,
    S_RMW_RD,
    S_STORE_LO,
    S_STORE_HI,
    S_RESP
  } lsu_state_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_D  = 3'b011;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  localparam logic [2:0] LSU_WU = 3'b110;

  localparam int LSU_PORT_BYTES = 4;

  // Access size in bytes from funct3[1:0].
  function automatic logic [63:0] lsu_size(input logic [1:0] sz);
    case (sz)
      2'b00:   lsu_size = 64'd1;
      2'b01:   lsu_size = 64'd2;
      2'b10:   lsu_size = 64'd4;
      default: lsu_size = 64'd8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational data path: load sign/zero extension from {hi, lo} and the SB/SH
// merge of new store data into a previously read word.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] cap_i,
  input  logic [15:0] wdata_i,
  output logic [63:0] ext_o,
  output logic [31:0] merge_o
);

  always_comb begin
    ext_o = {hi_i, lo_i};
    case (funct3_i)
      LSU_B:  ext_o = {{56{lo_i[7]}}, lo_i[7:0]};
      LSU_H:  ext_o = {{48{lo_i[15]}}, lo_i[15:0]};
      LSU_W:  ext_o = {{32{lo_i[31]}}, lo_i};
      LSU_D:  ext_o = {hi_i, lo_i};
      LSU_BU: ext_o = {56'b0, lo_i[7:0]};
      LSU_HU: ext_o = {48'b0, lo_i[15:0]};
      LSU_WU: ext_o = {32'b0, lo_i};
      default: ext_o = {hi_i, lo_i};
    endcase
  end

  // funct3[0] distinguishes SH (two bytes) from SB (one byte).
  always_comb begin
    merge_o = cap_i;
    if (funct3_i[0]) merge_o[15:0] = wdata_i;
    else             merge_o[7:0]  = wdata_i[7:0];
  end

endmodule

// File: rtl/load_store_unit.sv
// RV64 load-store unit over a 32-bit data memory port: splits doublewords, does RMW
// for SB/SH, extends loads. Optional bounds check enabled by LSU_BOUNDS_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic [63:0] mem_add,
  output logic [63:0] write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [63:0] read_data
);

  lsu_state_e  state_q, state_d;
  logic [2:0]  f3_q;
  logic [63:0] addr_q, wdata_q;
  logic [31:0] lo_q, hi_q;
  logic [63:0] resp_rdata_q;
  logic [4:0]  resp_rd_q;
  logic        resp_err_q;
  logic [63:0] mem_add_q, port_add;
  logic [31:0] wd_q, port_wd;
  logic        accept, oob, oob_chk, is_d;
  logic [31:0] lo_in, hi_in, merged;
  logic [63:0] ext, last_byte;
  logic        unused_rd_hi;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign is_d      = (f3_q[1:0] == 2'b11);

  // Last byte of the access, not of the 4-byte port; the first clause catches wrap.
  assign last_byte = req_addr + lsu_size(req_funct3[1:0]) - 64'd1;
  assign oob_chk   = (req_addr >= 64'(MEM_BYTES)) || (last_byte >= 64'(MEM_BYTES));
`ifdef LSU_BOUNDS_CHECK_EN
  assign oob = oob_chk;
`else
  logic unused_oob;
  assign unused_oob = oob_chk;
  assign oob = 1'b0;
`endif

  assign unused_rd_hi = ^read_data[63:32];

  // Words are captured at the edge leaving the read state, so extend from the live bus.
  assign lo_in = (state_q == S_LOAD_LO) ? read_data[31:0] : lo_q;
  assign hi_in = (state_q == S_LOAD_HI) ? read_data[31:0] : hi_q;

  lsu_byte_lane u_lane (
    .funct3_i (f3_q),
    .lo_i     (lo_in),
    .hi_i     (hi_in),
    .cap_i    (lo_q),
    .wdata_i  (wdata_q[15:0]),
    .ext_o    (ext),
    .merge_o  (merged)
  );

  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    port_add  = mem_add_q;
    port_wd   = wd_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (oob)                 state_d = S_RESP;
          else if (!req_is_store)  state_d = S_LOAD_LO;
          else if (req_funct3[1])  state_d = S_STORE_LO;
          else                     state_d = S_RMW_RD;
        end
      end
      S_LOAD_LO: begin
        mem_read = 1'b1;
        port_add = addr_q;
        state_d  = is_d ? S_LOAD_HI : S_RESP;
      end
      S_LOAD_HI: begin
        mem_read = 1'b1;
        port_add = addr_q + 64'(LSU_PORT_BYTES);
        state_d  = S_RESP;
      end
      S_RMW_RD: begin
        mem_read = 1'b1;
        port_add = addr_q;
        state_d  = S_STORE_LO;
      end
      S_STORE_LO: begin
        mem_write = 1'b1;
        port_add  = addr_q;
        port_wd   = f3_q[1] ? wdata_q[31:0] : merged;
        state_d   = is_d ? S_STORE_HI : S_RESP;
      end
      S_STORE_HI: begin
        mem_write = 1'b1;
        port_add  = addr_q + 64'(LSU_PORT_BYTES);
        port_wd   = wdata_q[63:32];
        state_d   = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
      resp_err_q   <= 1'b0;
      mem_add_q    <= '0;
      wd_q         <= '0;
    end else begin
      state_q   <= state_d;
      mem_add_q <= port_add;
      wd_q      <= port_wd;
      if (accept) begin
        f3_q         <= req_funct3;
        addr_q       <= req_addr;
        wdata_q      <= req_wdata;
        resp_rd_q    <= req_rd;
        resp_err_q   <= oob;
        resp_rdata_q <= '0;
      end
      case (state_q)
        S_LOAD_LO: begin
          lo_q <= read_data[31:0];
          if (!is_d) resp_rdata_q <= ext;
        end
        S_LOAD_HI: begin
          hi_q         <= read_data[31:0];
          resp_rdata_q <= ext;
        end
        S_RMW_RD: lo_q <= read_data[31:0];
        default: ;
      endcase
    end
  end

  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_rd    = resp_rd_q;
  assign resp_err   = resp_err_q;
  assign mem_add    = port_add;
  assign write_data = {32'b0, port_wd};

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [63:0] mem_add, write_data, read_data;
  logic        mem_write, mem_read;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(512)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_add(mem_add), .write_data(write_data), .mem_write(mem_write),
    .mem_read(mem_read), .read_data(read_data)
  );

  // Byte memory model, wraps modulo 512.
  logic [7:0] mem [0:511];
  logic [8:0] ma;
  assign ma = mem_add[8:0];
  assign read_data = {32'b0, mem[ma + 9'd3], mem[ma + 9'd2], mem[ma + 9'd1], mem[ma]};

  typedef struct { logic [63:0] a; logic [63:0] d; int c; } wr_t;
  wr_t wlog[$];
  int  cyc = 0;
  int  acc_cnt = 0;

  always @(posedge clk) begin
    if (mem_write) begin
      for (int k = 0; k < 4; k++) mem[ma + 9'(k)] = write_data[8*k +: 8];
      wlog.push_back('{a: mem_add, d: write_data, c: cyc});
    end
    if (mem_read || mem_write) acc_cnt++;
    cyc++;
  end

  task automatic poke32(input logic [8:0] a, input logic [31:0] v);
    for (int k = 0; k < 4; k++) mem[a + 9'(k)] = v[8*k +: 8];
  endtask

  function automatic logic [31:0] peek32(input logic [8:0] a);
    return {mem[a + 9'd3], mem[a + 9'd2], mem[a + 9'd1], mem[a]};
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct { logic [63:0] rdata; logic [4:0] rd; logic err; } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got rd %0d with no expectation queued", resp_rd);
      end else begin
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_rd", {59'b0, resp_rd}, {59'b0, e.rd});
        chk("resp_err", {63'b0, resp_err}, {63'b0, e.err});
      end
    end
  end

  // Issue one request, queue its expectation, check latency; complete the handshake
  // when resp_ready is high.
  task automatic req(input logic st, input logic [2:0] f3, input logic [63:0] a,
                     input logic [63:0] wd, input logic [4:0] rd,
                     input logic [63:0] exp_rdata, input logic exp_err, input int exp_lat);
    int lat;
    lat = 0;
    while (!req_ready && lat < 50) begin @(posedge clk); #1; lat++; end
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb.push_back('{rdata: exp_rdata, rd: rd, err: exp_err});
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", 64'(lat), 64'(exp_lat));
    if (resp_ready) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    req_valid = 0; req_is_store = 0; req_funct3 = 0; req_addr = 0;
    req_wdata = 0; req_rd = 0; resp_ready = 1;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;

    #2;
    chk("rst_req_ready", {63'b0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    chk("rst_mem_rw", {62'b0, mem_read, mem_write}, 64'd0);
    chk("rst_mem_add", mem_add, 64'd0);
    chk("rst_write_data", write_data, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_err", {63'b0, resp_err}, 64'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    // Byte / half / word loads with sign and zero extension.
    poke32(9'h100, 32'h0000_00F0);
    poke32(9'h120, 32'h8000_0001);
    req(0, 3'b000, 64'h100, 0, 5'd1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 2);
    req(0, 3'b100, 64'h100, 0, 5'd2, 64'h0000_0000_0000_00F0, 0, 2);
    req(0, 3'b010, 64'h120, 0, 5'd3, 64'hFFFF_FFFF_8000_0001, 0, 2);
    req(0, 3'b110, 64'h120, 0, 5'd4, 64'h0000_0000_8000_0001, 0, 2);
    req(0, 3'b101, 64'h120, 0, 5'd5, 64'h0000_0000_0000_0001, 0, 2);
    req(0, 3'b001, 64'h122, 0, 5'd6, 64'hFFFF_FFFF_FFFF_8000, 0, 2);

    // SD split into two consecutive word writes, then LD back.
    wlog.delete();
    req(1, 3'b011, 64'h108, 64'h1122_3344_5566_7788, 5'd10, 64'd0, 0, 3);
    chk("sd_write_count", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      chk("sd_lo_addr", wlog[0].a, 64'h108);
      chk("sd_lo_data", wlog[0].d, 64'h0000_0000_5566_7788);
      chk("sd_hi_addr", wlog[1].a, 64'h10C);
      chk("sd_hi_data", wlog[1].d, 64'h0000_0000_1122_3344);
      chk("sd_consecutive", 64'(wlog[1].c - wlog[0].c), 64'd1);
    end
    req(0, 3'b011, 64'h108, 0, 5'd11, 64'h1122_3344_5566_7788, 0, 3);

    // Sub-word stores through read-modify-write, plus a plain SW.
    poke32(9'h104, 32'hAABB_CCDD);
    req(1, 3'b000, 64'h104, 64'h1122_3344_5566_77EE, 5'd12, 64'd0, 0, 3);
    chk("sb_mem", {32'b0, peek32(9'h104)}, 64'h0000_0000_AABB_CCEE);
    req(0, 3'b010, 64'h104, 0, 5'd13, 64'hFFFF_FFFF_AABB_CCEE, 0, 2);
    poke32(9'h104, 32'hAABB_CCDD);
    req(1, 3'b101, 64'h104, 64'hFFFF_FFFF_FFFF_1234, 5'd14, 64'd0, 0, 3);
    chk("sh_mem", {32'b0, peek32(9'h104)}, 64'h0000_0000_AABB_1234);
    req(0, 3'b110, 64'h104, 0, 5'd15, 64'h0000_0000_AABB_1234, 0, 2);
    req(1, 3'b010, 64'h130, 64'h9999_9999_CAFE_F00D, 5'd16, 64'd0, 0, 2);
    chk("sw_mem_lo", {32'b0, peek32(9'h130)}, 64'h0000_0000_CAFE_F00D);
    chk("sw_mem_hi", {32'b0, peek32(9'h134)}, 64'd0);

    // Back-pressure: response held 5 cycles, next request waits for the handshake.
    resp_ready = 1'b0;
    req(0, 3'b010, 64'h120, 0, 5'd7, 64'hFFFF_FFFF_8000_0001, 0, 2);
    req_valid = 1'b1; req_is_store = 0; req_funct3 = 3'b110;
    req_addr = 64'h120; req_wdata = 0; req_rd = 5'd8;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {63'b0, resp_valid}, 64'd1);
      chk("hold_rdata", resp_rdata, 64'hFFFF_FFFF_8000_0001);
      chk("hold_rd", {59'b0, resp_rd}, 64'd7);
      chk("hold_req_ready", {63'b0, req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_req_ready", {63'b0, req_ready}, 64'd1);
    chk("post_hs_valid", {63'b0, resp_valid}, 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("next_accept_read", {63'b0, mem_read}, 64'd1);
    sb.push_back('{rdata: 64'h0000_0000_8000_0001, rd: 5'd8, err: 1'b0});
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("next_resp_seen", {63'b0, resp_valid}, 64'd1);
    @(posedge clk); #1;

    // Asynchronous reset during STORE_HI of an SD: only the low word lands.
    poke32(9'h140, 32'h0);
    poke32(9'h144, 32'h0102_0304);
    req_valid = 1'b1; req_is_store = 1; req_funct3 = 3'b011;
    req_addr = 64'h140; req_wdata = 64'hCAFE_BABE_DEAD_BEEF; req_rd = 5'd20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("sthi_mem_write", {63'b0, mem_write}, 64'd1);
    chk("sthi_mem_add", mem_add, 64'h144);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_mem_write", {63'b0, mem_write}, 64'd0);
    chk("arst_req_ready", {63'b0, req_ready}, 64'd1);
    chk("arst_resp_valid", {63'b0, resp_valid}, 64'd0);
    chk("arst_mem_add", mem_add, 64'd0);
    chk("arst_write_data", write_data, 64'd0);
    chk("arst_resp_rd", {59'b0, resp_rd}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("arst_lo_written", {32'b0, peek32(9'h140)}, 64'h0000_0000_DEAD_BEEF);
    chk("arst_hi_untouched", {32'b0, peek32(9'h144)}, 64'h0000_0000_0102_0304);
    req(0, 3'b010, 64'h140, 0, 5'd21, 64'hFFFF_FFFF_DEAD_BEEF, 0, 2);

`ifdef LSU_BOUNDS_CHECK_EN
    poke32(9'h1FC, 32'h7F00_0000);
    n = acc_cnt;
    req(0, 3'b010, 64'h1FE, 0, 5'd22, 64'd0, 1, 1);
    chk("oob_no_access", 64'(acc_cnt - n), 64'd0);
    req(0, 3'b000, 64'h1FF, 0, 5'd23, 64'h0000_0000_0000_007F, 0, 2);
`endif

    n = 0;
    while (sb.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
